// File: rtl/ps_ram_rd_ctrl_pkg.sv
// ps_ram_rd_ctrl_pkg
// Constants and types shared by the playback RAM read controller and its
// sub-module. The capture-side write controller uses the same bank depth,
// so DEPTH lives here rather than inside either controller.
//   DEPTH      samples per bank (last address DEPTH-1)
//   AW         RAM address width
//   DW         sample width
//   rd_state_e read FSM state encoding
package ps_ram_rd_ctrl_pkg;

    localparam int unsigned DEPTH = 35500;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_FETCH   = 2'd2,
        ST_CAPTURE = 2'd3
    } rd_state_e;

endpackage

// File: rtl/ps_ram_rd_ctrl_sync_rise_det.sv
// sync_rise_det
// Two-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector. rise_out is a one-cycle pulse that is high in the
// cycle after the second synchronizer flop first captures a 1, so a level
// change becomes a registered effect downstream three edges after it is
// first sampled.
//   clk       destination clock
//   rst_n     asynchronous active-low reset
//   async_in  level from another clock domain
//   rise_out  one-cycle pulse per rising edge of async_in
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_out = sync_q & ~prev_q;

endmodule

// File: rtl/ps_ram_rd_ctrl.sv
// ps_ram_rd_ctrl
// Ping-pong RAM read controller for the playback path. The PS fills two
// sample banks; this block streams one sample per DAC request out of the
// bank currently being read, reports which banks need a refill, and flags
// underruns (a request with no loaded bank).
//
// Handshake: dac_req is a one-cycle request pulse. The answer is a
// one-cycle dac_vld_out strobe with dac_data_out valid in the same cycle,
// two cycles after a serviced request or one cycle after a request that
// arrives with nothing loaded (data 0). Requests seen in FETCH/CAPTURE are
// dropped; the DAC spaces requests at least three cycles apart.
//
// Ports:
//   clk_100m, rst_n                system clock, async active-low reset
//   dac_req                        next-sample request pulse
//   sd_load_done                   PS level; each rising edge = bank filled
//   ram_dout1, ram_dout2           bank read data, one-cycle latency
//   en_rd1_out, en_rd2_out         bank read enables
//   addr_rd_out                    shared read address
//   dac_data_out, dac_vld_out      sample and its strobe
//   ram_1_empty_out, ram_2_empty_out  bank needs refill
//   underrun_out                   sticky underrun flag, cleared by reset
//   dbg_state_out                  current FSM state
module ps_ram_rd_ctrl
    import ps_ram_rd_ctrl_pkg::*;
#(
    parameter int unsigned BANK_DEPTH = DEPTH
) (
    input  logic          clk_100m,
    input  logic          rst_n,
    input  logic          dac_req,
    input  logic          sd_load_done,
    input  logic [DW-1:0] ram_dout1,
    input  logic [DW-1:0] ram_dout2,
    output logic          en_rd1_out,
    output logic          en_rd2_out,
    output logic [AW-1:0] addr_rd_out,
    output logic [DW-1:0] dac_data_out,
    output logic          dac_vld_out,
    output logic          ram_1_empty_out,
    output logic          ram_2_empty_out,
    output logic          underrun_out,
    output logic [1:0]    dbg_state_out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(BANK_DEPTH - 1);

    rd_state_e     state_q, state_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          rd_bank_q, rd_bank_d;
    logic          load_ptr_q, load_ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dac_data_q, dac_data_d;
    logic          dac_vld_q, dac_vld_d;
    logic          underrun_q, underrun_d;

    logic          load_rise;
    logic [1:0]    bank_clr;
    logic [1:0]    bank_kept;
    logic          bank_swap;
    logic          en_rd1, en_rd2;

    sync_rise_det u_load_sync (
        .clk      (clk_100m),
        .rst_n    (rst_n),
        .async_in (sd_load_done),
        .rise_out (load_rise)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_bank_d  = rd_bank_q;
        dac_data_d = dac_data_q;
        dac_vld_d  = 1'b0;
        underrun_d = underrun_q;
        bank_clr   = 2'b00;
        bank_swap  = 1'b0;
        en_rd1     = 1'b0;
        en_rd2     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Nothing to play: answer with silence so the DAC keeps
                // its frame timing, and remember that it happened.
                if (dac_req) begin
                    dac_data_d = '0;
                    dac_vld_d  = 1'b1;
                    underrun_d = 1'b1;
                end
                if (bank_full_q[rd_bank_q]) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (dac_req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                en_rd1  = ~rd_bank_q;
                en_rd2  = rd_bank_q;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                dac_data_d = rd_bank_q ? ram_dout2 : ram_dout1;
                dac_vld_d  = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d             = '0;
                    bank_clr[rd_bank_q] = 1'b1;
                    rd_bank_d          = ~rd_bank_q;
                    bank_swap          = 1'b1;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load is accepted only into a bank that is empty once this
        // cycle's clear is applied, so a load landing on the bank that is
        // just being released still takes effect (set wins over clear).
        bank_kept   = bank_full_q & ~bank_clr;
        bank_full_d = bank_kept;
        load_ptr_d  = load_ptr_q;
        if (load_rise && !bank_kept[load_ptr_q]) begin
            bank_full_d[load_ptr_q] = 1'b1;
            load_ptr_d              = ~load_ptr_q;
        end

        // After a swap, continue straight on if the other bank is ready.
        if (bank_swap) begin
            state_d = bank_full_d[rd_bank_d] ? ST_READY : ST_IDLE;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_full_q <= 2'b00;
            rd_bank_q   <= 1'b0;
            load_ptr_q  <= 1'b0;
            addr_q      <= '0;
            dac_data_q  <= '0;
            dac_vld_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            rd_bank_q   <= rd_bank_d;
            load_ptr_q  <= load_ptr_d;
            addr_q      <= addr_d;
            dac_data_q  <= dac_data_d;
            dac_vld_q   <= dac_vld_d;
            underrun_q  <= underrun_d;
        end
    end

    // Read enables decode straight from state so an asynchronous reset
    // during FETCH removes them immediately.
    assign en_rd1_out      = en_rd1;
    assign en_rd2_out      = en_rd2;
    assign addr_rd_out     = addr_q;
    assign dac_data_out    = dac_data_q;
    assign dac_vld_out     = dac_vld_q;
    assign ram_1_empty_out = ~bank_full_q[0];
    assign ram_2_empty_out = ~bank_full_q[1];
    assign underrun_out    = underrun_q;
    assign dbg_state_out   = state_q;

endmodule

// File: tb/tb_ps_ram_rd_ctrl.sv
module tb_ps_ram_rd_ctrl;
    import ps_ram_rd_ctrl_pkg::*;

    localparam int unsigned TB_DEPTH = 6;

    logic          clk_100m = 1'b0;
    logic          rst_n = 1'b0;
    logic          dac_req = 1'b0;
    logic          sd_load_done = 1'b0;
    logic [DW-1:0] ram_dout1 = '0;
    logic [DW-1:0] ram_dout2 = '0;
    logic          en_rd1_out, en_rd2_out;
    logic [AW-1:0] addr_rd_out;
    logic [DW-1:0] dac_data_out;
    logic          dac_vld_out;
    logic          ram_1_empty_out, ram_2_empty_out;
    logic          underrun_out;
    logic [1:0]    dbg_state_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    ps_ram_rd_ctrl #(.BANK_DEPTH(TB_DEPTH)) dut (
        .clk_100m        (clk_100m),
        .rst_n           (rst_n),
        .dac_req         (dac_req),
        .sd_load_done    (sd_load_done),
        .ram_dout1       (ram_dout1),
        .ram_dout2       (ram_dout2),
        .en_rd1_out      (en_rd1_out),
        .en_rd2_out      (en_rd2_out),
        .addr_rd_out     (addr_rd_out),
        .dac_data_out    (dac_data_out),
        .dac_vld_out     (dac_vld_out),
        .ram_1_empty_out (ram_1_empty_out),
        .ram_2_empty_out (ram_2_empty_out),
        .underrun_out    (underrun_out),
        .dbg_state_out   (dbg_state_out)
    );

    // clock / reset
    always #5 clk_100m = ~clk_100m;

    // Registered sample RAMs: bank 1 holds its address, bank 2 holds
    // 0x8000 | address.
    always @(posedge clk_100m) begin
        if (en_rd1_out) ram_dout1 <= addr_rd_out;
        if (en_rd2_out) ram_dout2 <= 16'h8000 | addr_rd_out;
    end

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        dac_req = 1'b0;
        sd_load_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One full rising/falling pulse of sd_load_done; the bank is marked
    // full on the third edge after the rise.
    task automatic pulse_load();
        sd_load_done = 1'b1;
        repeat (4) tick();
        sd_load_done = 1'b0;
        repeat (3) tick();
    endtask

    // Issue one request from READY and return what was observed over the
    // following three cycles.
    task automatic do_req(output logic o_en1, output logic o_en2,
                          output logic [AW-1:0] o_addr, output logic o_vld_early,
                          output logic o_vld, output logic [DW-1:0] o_data);
        dac_req = 1'b1;
        tick();
        dac_req = 1'b0;
        o_en1 = en_rd1_out;
        o_en2 = en_rd2_out;
        o_addr = addr_rd_out;
        o_vld_early = dac_vld_out;
        tick();
        o_vld_early = o_vld_early | dac_vld_out;
        tick();
        o_vld = dac_vld_out;
        o_data = dac_data_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        vec_cnt++; if (en_rd1_out !== 1'b0 || en_rd2_out !== 1'b0) begin err_cnt++; $display("FAIL reset_en: got %b%b want 00", en_rd1_out, en_rd2_out); end
        vec_cnt++; if (addr_rd_out !== 16'd0) begin err_cnt++; $display("FAIL reset_addr: got %0d want 0", addr_rd_out); end
        vec_cnt++; if (dac_data_out !== 16'd0 || dac_vld_out !== 1'b0) begin err_cnt++; $display("FAIL reset_dac: got %h/%b want 0000/0", dac_data_out, dac_vld_out); end
        vec_cnt++; if (ram_1_empty_out !== 1'b1 || ram_2_empty_out !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b%b want 11", ram_1_empty_out, ram_2_empty_out); end
        vec_cnt++; if (underrun_out !== 1'b0) begin err_cnt++; $display("FAIL reset_underrun: got %b want 0", underrun_out); end
        vec_cnt++; if (dbg_state_out !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d want 0", dbg_state_out); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_underrun();
        apply_reset();
        dac_req = 1'b1;
        tick();
        dac_req = 1'b0;
        vec_cnt++; if (dac_vld_out !== 1'b1) begin err_cnt++; $display("FAIL underrun_vld: got %b want 1", dac_vld_out); end
        vec_cnt++; if (dac_data_out !== 16'd0) begin err_cnt++; $display("FAIL underrun_data: got %h want 0000", dac_data_out); end
        vec_cnt++; if (underrun_out !== 1'b1) begin err_cnt++; $display("FAIL underrun_flag: got %b want 1", underrun_out); end
        tick();
        vec_cnt++; if (dac_vld_out !== 1'b0) begin err_cnt++; $display("FAIL underrun_vld_width: got %b want 0", dac_vld_out); end
        vec_cnt++; if (underrun_out !== 1'b1) begin err_cnt++; $display("FAIL underrun_sticky: got %b want 1", underrun_out); end
        vec_cnt++; if (ram_1_empty_out !== 1'b1 || ram_2_empty_out !== 1'b1) begin err_cnt++; $display("FAIL underrun_empty: got %b%b want 11", ram_1_empty_out, ram_2_empty_out); end
    endtask

    task automatic test_single_bank();
        logic e1, e2, ve, v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        apply_reset();
        sd_load_done = 1'b1;
        repeat (2) tick();
        vec_cnt++; if (ram_1_empty_out !== 1'b1) begin err_cnt++; $display("FAIL load_early: got %b want 1", ram_1_empty_out); end
        tick();
        vec_cnt++; if (ram_1_empty_out !== 1'b0 || ram_2_empty_out !== 1'b1) begin err_cnt++; $display("FAIL load_latency: got %b%b want 01", ram_1_empty_out, ram_2_empty_out); end
        tick();
        sd_load_done = 1'b0;
        vec_cnt++; if (dbg_state_out !== 2'd1) begin err_cnt++; $display("FAIL load_ready: got %0d want 1", dbg_state_out); end
        for (int i = 0; i < 3; i++) begin
            do_req(e1, e2, a, ve, v, d);
            vec_cnt++; if (e1 !== 1'b1 || e2 !== 1'b0) begin err_cnt++; $display("FAIL single_en[%0d]: got %b%b want 10", i, e1, e2); end
            vec_cnt++; if (a !== AW'(i)) begin err_cnt++; $display("FAIL single_addr[%0d]: got %0d want %0d", i, a, i); end
            vec_cnt++; if (ve !== 1'b0 || v !== 1'b1) begin err_cnt++; $display("FAIL single_vld[%0d]: got early %b at2 %b want 0/1", i, ve, v); end
            vec_cnt++; if (d !== DW'(i)) begin err_cnt++; $display("FAIL single_data[%0d]: got %h want %h", i, d, DW'(i)); end
        end
        vec_cnt++; if (underrun_out !== 1'b0) begin err_cnt++; $display("FAIL single_underrun: got %b want 0", underrun_out); end
    endtask

    task automatic test_swap();
        logic e1, e2, ve, v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;
        logic [AW-1:0] exp_a;
        apply_reset();
        pulse_load();
        pulse_load();
        vec_cnt++; if (ram_1_empty_out !== 1'b0 || ram_2_empty_out !== 1'b0) begin err_cnt++; $display("FAIL swap_loaded: got %b%b want 00", ram_1_empty_out, ram_2_empty_out); end
        for (int i = 0; i < int'(TB_DEPTH) + 2; i++) begin
            exp_a = (i < int'(TB_DEPTH)) ? AW'(i) : AW'(i - int'(TB_DEPTH));
            exp_d = (i < int'(TB_DEPTH)) ? DW'(i) : (16'h8000 | DW'(i - int'(TB_DEPTH)));
            do_req(e1, e2, a, ve, v, d);
            vec_cnt++; if (e1 !== (i < int'(TB_DEPTH)) || e2 !== (i >= int'(TB_DEPTH))) begin err_cnt++; $display("FAIL swap_en[%0d]: got %b%b", i, e1, e2); end
            vec_cnt++; if (a !== exp_a) begin err_cnt++; $display("FAIL swap_addr[%0d]: got %0d want %0d", i, a, exp_a); end
            vec_cnt++; if (v !== 1'b1 || d !== exp_d) begin err_cnt++; $display("FAIL swap_data[%0d]: got %b/%h want 1/%h", i, v, d, exp_d); end
            if (i == int'(TB_DEPTH) - 1) begin
                vec_cnt++; if (ram_1_empty_out !== 1'b1 || ram_2_empty_out !== 1'b0) begin err_cnt++; $display("FAIL swap_empty: got %b%b want 10", ram_1_empty_out, ram_2_empty_out); end
                vec_cnt++; if (dbg_state_out !== 2'd1) begin err_cnt++; $display("FAIL swap_state: got %0d want 1", dbg_state_out); end
            end
        end
        vec_cnt++; if (underrun_out !== 1'b0) begin err_cnt++; $display("FAIL swap_underrun: got %b want 0", underrun_out); end
    endtask

    task automatic test_ignore_third();
        logic e1, e2, ve, v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        apply_reset();
        pulse_load();
        pulse_load();
        pulse_load();
        vec_cnt++; if (ram_1_empty_out !== 1'b0 || ram_2_empty_out !== 1'b0) begin err_cnt++; $display("FAIL third_empty: got %b%b want 00", ram_1_empty_out, ram_2_empty_out); end
        for (int i = 0; i < int'(TB_DEPTH); i++) do_req(e1, e2, a, ve, v, d);
        vec_cnt++; if (ram_1_empty_out !== 1'b1) begin err_cnt++; $display("FAIL third_drained: got %b want 1", ram_1_empty_out); end
        sd_load_done = 1'b1;
        repeat (2) tick();
        vec_cnt++; if (ram_1_empty_out !== 1'b1) begin err_cnt++; $display("FAIL refill_early: got %b want 1", ram_1_empty_out); end
        tick();
        vec_cnt++; if (ram_1_empty_out !== 1'b0 || ram_2_empty_out !== 1'b0) begin err_cnt++; $display("FAIL refill_bank1: got %b%b want 00", ram_1_empty_out, ram_2_empty_out); end
        sd_load_done = 1'b0;
        tick();
        do_req(e1, e2, a, ve, v, d);
        vec_cnt++; if (e2 !== 1'b1 || v !== 1'b1 || d !== 16'h8000) begin err_cnt++; $display("FAIL refill_play: got en2 %b vld %b data %h want 1/1/8000", e2, v, d); end
    endtask

    task automatic test_clear_set_same_cycle();
        logic e1, e2, ve, v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        apply_reset();
        pulse_load();
        pulse_load();
        for (int i = 0; i < int'(TB_DEPTH) - 1; i++) do_req(e1, e2, a, ve, v, d);
        // load rise lands on the CAPTURE edge of the last bank-1 address
        dac_req = 1'b1;
        sd_load_done = 1'b1;
        tick();
        dac_req = 1'b0;
        repeat (2) tick();
        vec_cnt++; if (dac_vld_out !== 1'b1 || dac_data_out !== DW'(TB_DEPTH - 1)) begin err_cnt++; $display("FAIL clrset_last: got %b/%h want 1/%h", dac_vld_out, dac_data_out, DW'(TB_DEPTH - 1)); end
        vec_cnt++; if (ram_1_empty_out !== 1'b0 || ram_2_empty_out !== 1'b0) begin err_cnt++; $display("FAIL clrset_full: got %b%b want 00", ram_1_empty_out, ram_2_empty_out); end
        sd_load_done = 1'b0;
        do_req(e1, e2, a, ve, v, d);
        vec_cnt++; if (e2 !== 1'b1 || a !== 16'd0 || d !== 16'h8000) begin err_cnt++; $display("FAIL clrset_next: got en2 %b addr %0d data %h want 1/0/8000", e2, a, d); end
    endtask

    task automatic test_reset_mid_read();
        logic e1, e2, ve, v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic saw_vld;
        apply_reset();
        pulse_load();
        do_req(e1, e2, a, ve, v, d);
        do_req(e1, e2, a, ve, v, d);
        dac_req = 1'b1;
        tick();
        dac_req = 1'b0;
        vec_cnt++; if (en_rd1_out !== 1'b1 || addr_rd_out !== 16'd2) begin err_cnt++; $display("FAIL mid_fetch: got en1 %b addr %0d want 1/2", en_rd1_out, addr_rd_out); end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (en_rd1_out !== 1'b0 || addr_rd_out !== 16'd0) begin err_cnt++; $display("FAIL mid_rst_rd: got en1 %b addr %0d want 0/0", en_rd1_out, addr_rd_out); end
        vec_cnt++; if (dac_data_out !== 16'd0 || dac_vld_out !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_dac: got %h/%b want 0000/0", dac_data_out, dac_vld_out); end
        vec_cnt++; if (ram_1_empty_out !== 1'b1 || ram_2_empty_out !== 1'b1 || underrun_out !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_flags: got %b%b%b want 110", ram_1_empty_out, ram_2_empty_out, underrun_out); end
        saw_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_vld = saw_vld | dac_vld_out;
        end
        vec_cnt++; if (saw_vld !== 1'b0 || dbg_state_out !== 2'd0) begin err_cnt++; $display("FAIL mid_rst_after: got vld %b state %0d want 0/0", saw_vld, dbg_state_out); end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_single_bank();
        test_swap();
        test_ignore_third();
        test_clear_set_same_cycle();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ps_ram_rd_ctrl.md
# ps_ram_rd_ctrl

Ping-pong RAM read controller for the playback path: the PS fills two sample RAM banks from SD card; this block streams samples out of the RAMs to the WM8731 DAC transmitter, one per DAC request. It tells the PS which bank is empty and needs a refill, and flags underruns. It is the read-side counterpart of the FIR capture write controller and uses the same bank depth and load-done handshake style.

## Interface
- DEPTH, 35500, samples per bank; last address is DEPTH-1
- AW, 16, RAM address width
- DW, 16, sample width
- clk_100m  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- dac_req  in  1  one-cycle pulse from DAC transmitter requesting the next sample
- sd_load_done  in  1  PS level signal; each rising edge means "bank at load pointer filled"
- ram_dout1, ram_dout2  in  DW  read data of bank 1 / bank 2; registered RAM, 1-cycle read latency
- en_rd1_out, en_rd2_out  out  1  RAM read enables
- addr_rd_out  out  AW  shared read address
- dac_data_out  out  DW  sample to the DAC transmitter
- dac_vld_out  out  1  one-cycle strobe; dac_data_out is valid in that cycle
- ram_1_empty_out, ram_2_empty_out  out  1  level; bank needs a refill from the PS
- underrun_out  out  1  sticky; a request arrived with no loaded bank

## Operation
- State: bank_full[1:0], rd_bank (0 = bank 1), load_ptr (0 = bank 1), addr, and FSM {IDLE, READY, FETCH, CAPTURE}.
- sd_load_done goes through a 2-flop synchronizer and rising-edge detector. Each detected edge sets bank_full[load_ptr] and toggles load_ptr, but only if bank_full[load_ptr] is 0 after this cycle's clear. Otherwise the edge is ignored.
- IDLE: move to READY when bank_full[rd_bank] is 1. A dac_req in IDLE loads dac_data_out with 0, pulses dac_vld_out and sets underrun_out.
- READY: on dac_req, go to FETCH.
- FETCH: assert en_rdN for rd_bank with addr_rd_out = addr, then go to CAPTURE.
- CAPTURE:
  - Register ram_doutN of rd_bank into dac_data_out and pulse dac_vld_out.
  - If addr = DEPTH-1: set addr to 0, clear bank_full[rd_bank], toggle rd_bank. Next state is READY if the new bank is full, else IDLE.
  - Otherwise increment addr and go to READY.
- dac_req arriving in FETCH or CAPTURE is dropped. Requests come at the audio rate, so they are always ≥3 cycles apart.
- ram_N_empty_out = ~bank_full[N-1].
- When a bank clear and a load set hit the same bank in the same cycle, the set wins and the bank ends full.

## Timing
- Reset values:
  - FSM IDLE; bank_full 00; rd_bank 0; load_ptr 0; addr 0.
  - en_rd1_out and en_rd2_out 0; addr_rd_out 0.
  - dac_data_out 0; dac_vld_out 0; underrun_out 0.
  - ram_1_empty_out and ram_2_empty_out both 1.
- Read latency: dac_req is sampled at edge k. en_rd is high during cycle k→k+1. dac_vld_out is high during cycle k+2→k+3.
- Underrun response: dac_vld_out is high in the cycle after the edge that sampled the request.
- sd_load_done edge → bank_full, and the corresponding empty output, update 3 edges later.
- Bank swap and clearing of bank_full happen at the CAPTURE edge of address DEPTH-1. The empty output rises in the cycle that edge starts.
- Reset asserted mid-read aborts immediately to reset values. In-flight samples are discarded and the PS must reload both banks.
- The underrun flag is cleared only by reset.

## Structure
- Shared package: DEPTH, AW, DW, and the FSM state enum. The write controller uses the same DEPTH.
- One sub-module, sync_rise_det: 2-flop synchronizer plus rising-edge pulse. It is reusable by the write controller's sd_carry_done path.

## Test plan
- Reset, then dac_req with no load → dac_vld one cycle later, dac_data 0, underrun_out 1, both empty outputs stay 1.
- Load bank 1 (ram_dout1 = addr), then 3 requests → dac_data 0, 1, 2. Each dac_vld appears 2 cycles after its request, and en_rd1 pulses at addresses 0, 1, 2.
- Load both banks, then play DEPTH+2 samples → at address 35499 the output switches to bank 2 data starting at address 0, ram_1_empty_out rises, and no underrun.
- Third sd_load_done edge while both banks are full → ignored, load_ptr unchanged. Refill after bank 1 is empty → ram_1_empty_out falls 3 cycles after the edge.
- Load edge in the same cycle as bank 1 is cleared at its last sample → bank 1 ends full.
- Reset asserted between FETCH and CAPTURE → no dac_vld, all outputs at reset values in the same cycle.
